// File: rtl/aes_param_decipher_block.sv
`default_nettype none
// ==================================================================
// Module   : aes_param_decipher_block
// Brief    : Iterative AES inverse cipher; SBOX_WORDS words are
//            inverse-substituted per cycle. Defining AES_DEC_ABORT_EN
//            adds an abort input.
// Revision : 1.0
// ==================================================================
module aes_param_decipher_block #(
  parameter int SBOX_WORDS = 1
) (
  input  logic         clk,
  input  logic         reset_n,
`ifdef AES_DEC_ABORT_EN
  input  logic         abort,
`endif
  input  logic         next,
  input  logic [1:0]   keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready,
  output logic         keylen_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    SBOX = 2'd2,
    MAIN = 2'd3
  } state_t;

  localparam int         c_sbox_cycles = 4 / SBOX_WORDS;
  localparam logic [1:0] c_ctr_last    = 2'(c_sbox_cycles - 1);

  // Inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] c_inv_sbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] f_inv_sbox(input logic [7:0] x);
    return c_inv_sbox[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] f_inv_sub_word(input logic [31:0] w);
    return {f_inv_sbox(w[31:24]), f_inv_sbox(w[23:16]),
            f_inv_sbox(w[15:8]),  f_inv_sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] f_word(input logic [127:0] s, input logic [1:0] i);
    case (i)
      2'd0:    return s[127:96];
      2'd1:    return s[95:64];
      2'd2:    return s[63:32];
      default: return s[31:0];
    endcase
  endfunction

  function automatic logic [7:0] f_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] f_inv_mix_col(input logic [31:0] c);
    logic [3:0][7:0] m9, mb, md, me;
    logic [7:0] a, x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a  = c[31-8*i -: 8];
      x2 = f_xt(a);
      x4 = f_xt(x2);
      x8 = f_xt(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] f_inv_mix(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = f_inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  // Byte (row r, column c) sits at index 4*c + r counted from the MSB.
  function automatic logic [127:0] f_inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  state_t       r_fsm;
  logic [127:0] r_state;
  logic [3:0]   r_round;
  logic [1:0]   r_word_ctr;
  logic         r_ready;
  logic         r_keylen_err;

  logic         w_abort;
  logic [3:0]   w_nr;
  logic [127:0] w_add;
  logic [127:0] w_init;
  logic [127:0] w_main;
  logic [127:0] w_sbox_state;
  logic [1:0]   w_lane_idx [SBOX_WORDS];
  logic [31:0]  w_lane_out [SBOX_WORDS];

`ifdef AES_DEC_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_nr = 4'd0;
    case (keylen)
      2'b00:   w_nr = 4'd10;
      2'b01:   w_nr = 4'd14;
      2'b10:   w_nr = 4'd12;
      default: w_nr = 4'd0;
    endcase
  end

  assign w_add  = r_state ^ round_key;
  assign w_init = f_inv_shift_rows(block ^ round_key);
  assign w_main = f_inv_shift_rows(f_inv_mix(w_add));

  // One substitution lane per word handled in a cycle.
  for (genvar l = 0; l < SBOX_WORDS; l++) begin : g_lane
    assign w_lane_idx[l] = 2'(int'(r_word_ctr) * SBOX_WORDS + l);
    assign w_lane_out[l] = f_inv_sub_word(f_word(r_state, w_lane_idx[l]));
  end

  always_comb begin
    w_sbox_state = r_state;
    for (int l = 0; l < SBOX_WORDS; l++) begin
      case (w_lane_idx[l])
        2'd0:    w_sbox_state[127:96] = w_lane_out[l];
        2'd1:    w_sbox_state[95:64]  = w_lane_out[l];
        2'd2:    w_sbox_state[63:32]  = w_lane_out[l];
        default: w_sbox_state[31:0]   = w_lane_out[l];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm        <= IDLE;
      r_state      <= '0;
      r_round      <= '0;
      r_word_ctr   <= '0;
      r_ready      <= 1'b1;
      r_keylen_err <= 1'b0;
    end else begin
      r_keylen_err <= 1'b0;
      if (w_abort && (r_fsm != IDLE)) begin
        r_fsm      <= IDLE;
        r_state    <= '0;
        r_round    <= '0;
        r_word_ctr <= '0;
        r_ready    <= 1'b1;
      end else begin
        case (r_fsm)
          IDLE: begin
            if (next) begin
              if (keylen == 2'b11) begin
                r_keylen_err <= 1'b1;
              end else begin
                r_round <= w_nr;
                r_ready <= 1'b0;
                r_fsm   <= INIT;
              end
            end
          end
          INIT: begin
            r_state    <= w_init;
            r_word_ctr <= '0;
            r_fsm      <= SBOX;
          end
          SBOX: begin
            r_state <= w_sbox_state;
            if (r_word_ctr == c_ctr_last) begin
              r_word_ctr <= '0;
              r_round    <= r_round - 4'd1;
              r_fsm      <= MAIN;
            end else begin
              r_word_ctr <= r_word_ctr + 2'd1;
            end
          end
          MAIN: begin
            if (r_round == 4'd0) begin
              r_state <= w_add;
              r_ready <= 1'b1;
              r_fsm   <= IDLE;
            end else begin
              r_state <= w_main;
              r_fsm   <= SBOX;
            end
          end
          default: r_fsm <= IDLE;
        endcase
      end
    end
  end

  assign round      = r_round;
  assign new_block  = r_state;
  assign ready      = r_ready;
  assign keylen_err = r_keylen_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_param_decipher_block.sv
`default_nettype none
// Bench for aes_param_decipher_block: three instances (1, 2, 4 words per
// cycle) driven with FIPS-197 vectors against a scoreboard of expected plaintexts.
module tb_aes_param_decipher_block;

  localparam int NDUT = 3;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct packed {
    logic [1:0]   idx;
    logic [127:0] data;
    logic [7:0]   lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         next_s   [NDUT];
  logic [1:0]   keylen_s [NDUT];
  logic [3:0]   round_s  [NDUT];
  logic [127:0] rk_s     [NDUT];
  logic [127:0] blk_s    [NDUT];
  logic [127:0] nb_s     [NDUT];
  logic         ready_s  [NDUT];
  logic         err_s    [NDUT];
`ifdef AES_DEC_ABORT_EN
  logic         abort_s  [NDUT];
`endif
  logic [1:0]   kmodel   [NDUT];
  logic [127:0] rk_tab   [0:3][0:15];
  logic [7:0]   sbox_tab [256];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    aes_param_decipher_block #(.SBOX_WORDS(1 << g)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
`ifdef AES_DEC_ABORT_EN
      .abort      (abort_s[g]),
`endif
      .next       (next_s[g]),
      .keylen     (keylen_s[g]),
      .round      (round_s[g]),
      .round_key  (rk_s[g]),
      .block      (blk_s[g]),
      .new_block  (nb_s[g]),
      .ready      (ready_s[g]),
      .keylen_err (err_s[g])
    );
    assign rk_s[g] = rk_tab[kmodel[g]][round_s[g]];
  end

  // ---------------- key schedule model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b};
    return t[15-k -: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int v = 0; v < 256; v++) begin
      b   = 8'(v);
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, b);
      sbox_tab[v] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input int nk, input int code);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) rk_tab[code][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rk_tab[code][r] = '0;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input int idx, input logic [1:0] kl, input logic [127:0] blk,
                       input int nr, input string tag);
    exp_t e;
    e.idx  = 2'(idx);
    e.data = PT;
    e.lat  = 8'(1 + nr * (4 / (1 << idx) + 1));
    sb.push_back(e);
    kmodel[idx]   = kl;
    keylen_s[idx] = kl;
    blk_s[idx]    = blk;
    next_s[idx]   = 1'b1;
    @(posedge clk); #1;
    next_s[idx] = 1'b0;
    chk({tag, " ready low after start"}, ready_s[idx], 1'b0);
    chk({tag, " round loaded with Nr"}, round_s[idx], 128'(nr));
  endtask

  task automatic wait_done(input bit scramble, input string tag);
    exp_t e;
    int   n;
    bit   done, err_seen;
    e = sb[0];
    n = 0;
    done = 1'b0;
    err_seen = 1'b0;
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) blk_s[e.idx] = 128'hdeadbeef_cafef00d_01234567_89abcdef;
      if (err_s[e.idx]) err_seen = 1'b1;
      if (ready_s[e.idx]) done = 1'b1;
      else if (scramble) begin
        keylen_s[e.idx] = 2'(n);
        next_s[e.idx]   = n[0];
      end
    end
    next_s[e.idx] = 1'b0;
    chk({tag, " ready within budget"}, done, 1'b1);
    e = sb.pop_front();
    chk({tag, " plaintext"}, nb_s[e.idx], e.data);
    chk({tag, " latency"}, 128'(n), 128'(e.lat));
    if (scramble) chk({tag, " no keylen_err mid-run"}, err_seen, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      next_s[g]   = 1'b0;
      keylen_s[g] = 2'b00;
      blk_s[g]    = '0;
      kmodel[g]   = 2'b00;
`ifdef AES_DEC_ABORT_EN
      abort_s[g]  = 1'b0;
`endif
    end
    for (int r = 0; r < 16; r++) rk_tab[3][r] = '0;
    build_sbox();
    expand_key(4, 0);
    expand_key(8, 1);
    expand_key(6, 2);

    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("reset ready[%0d]", g), ready_s[g], 1'b1);
      chk($sformatf("reset new_block[%0d]", g), nb_s[g], '0);
      chk($sformatf("reset round[%0d]", g), round_s[g], '0);
      chk($sformatf("reset keylen_err[%0d]", g), err_s[g], 1'b0);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;

    start(0, 2'b00, C128, 10, "aes128 w1");
    wait_done(1'b0, "aes128 w1");
    repeat (3) @(posedge clk);
    #1;
    chk("idle hold new_block", nb_s[0], PT);
    chk("idle hold ready", ready_s[0], 1'b1);

    keylen_s[0] = 2'b11;
    next_s[0]   = 1'b1;
    @(posedge clk); #1;
    next_s[0] = 1'b0;
    chk("bad keylen err pulse", err_s[0], 1'b1);
    chk("bad keylen ready", ready_s[0], 1'b1);
    chk("bad keylen round", round_s[0], '0);
    @(posedge clk); #1;
    chk("bad keylen err cleared", err_s[0], 1'b0);
    chk("bad keylen still idle", ready_s[0], 1'b1);

    start(1, 2'b10, C192, 12, "aes192 w2");
    wait_done(1'b0, "aes192 w2");

    start(2, 2'b01, C256, 14, "aes256 w4 scrambled");
    wait_done(1'b1, "aes256 w4 scrambled");

    start(2, 2'b00, C128, 10, "b2b first w4");
    wait_done(1'b0, "b2b first w4");
    start(2, 2'b10, C192, 12, "b2b second w4");
    wait_done(1'b0, "b2b second w4");

    start(0, 2'b10, C192, 12, "aes192 w1");
    wait_done(1'b0, "aes192 w1");

    start(0, 2'b00, C128, 10, "reset run");
    repeat (20) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async reset new_block", nb_s[0], '0);
    chk("async reset ready", ready_s[0], 1'b1);
    chk("async reset round", round_s[0], '0);
    sb.delete(0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    start(0, 2'b00, C128, 10, "after reset w1");
    wait_done(1'b0, "after reset w1");

`ifdef AES_DEC_ABORT_EN
    start(1, 2'b00, C128, 10, "abort run");
    repeat (9) @(posedge clk);
    #1;
    abort_s[1] = 1'b1;
    next_s[1]  = 1'b1;
    @(posedge clk); #1;
    abort_s[1] = 1'b0;
    next_s[1]  = 1'b0;
    chk("abort ready", ready_s[1], 1'b1);
    chk("abort new_block", nb_s[1], '0);
    chk("abort round", round_s[1], '0);
    sb.delete(0);
    @(posedge clk); #1;
    chk("abort next ignored", ready_s[1], 1'b1);
    start(1, 2'b00, C128, 10, "after abort w2");
    wait_done(1'b0, "after abort w2");
`endif

    chk("scoreboard drained", 128'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation stalled");
  end

endmodule
`default_nettype wire

// File: doc/aes_param_decipher_block.md
AES_PARAM_DECIPHER_BLOCK -- requirements
Module: aes_param_decipher_block

Interface
REQ-001 SHALL have parameter SBOX_WORDS, default 1, giving the number of 32-bit words inverse-S-boxed per cycle; legal values are 1, 2 and 4.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset; asynchronous, active-low.
REQ-004 SHALL have port next, input, 1 bit: start request.
REQ-005 SHALL have port keylen, input, 2 bits: key size; 00 = AES-128, 01 = AES-256, 10 = AES-192, 11 = illegal.
REQ-006 SHALL have port round, output, 4 bits: index of the round key requested.
REQ-007 SHALL have port round_key, input, 128 bits: key for the current round index, valid in the same cycle.
REQ-008 SHALL have port block, input, 128 bits: ciphertext, sampled in INIT only.
REQ-009 SHALL have port new_block, output, 128 bits: state register, and the plaintext when ready is high after a run.
REQ-010 SHALL have port ready, output, 1 bit: high when idle.
REQ-011 SHALL have port keylen_err, output, 1 bit: one-cycle pulse flagging a rejected start.

Function
REQ-012 SHALL implement FSM states IDLE, INIT, SBOX, MAIN; encodings outside these SHALL return to IDLE on the next edge.
REQ-013 IDLE with next=1 and a legal keylen SHALL:
- latch keylen internally;
- load the round counter with Nr (10/12/14);
- clear ready;
- enter INIT.
REQ-014 keylen changes after start SHALL have no effect until the next start.
REQ-015 IDLE with next=1 and keylen=11 SHALL stay in IDLE with ready high, and SHALL pulse keylen_err for exactly one cycle.
REQ-016 next SHALL be ignored in every state other than IDLE.
REQ-017 INIT SHALL:
- load state = InvShiftRows(block XOR round_key);
- clear the S-box word counter;
- go to SBOX.
REQ-018 SBOX SHALL replace SBOX_WORDS consecutive words per cycle, starting at word 0 (bits 127:96), with their byte-wise inverse S-box.
REQ-019 SBOX SHALL last 4/SBOX_WORDS cycles; on its last cycle it SHALL decrement the round counter and go to MAIN.
REQ-020 MAIN with round > 0 SHALL load state = InvShiftRows(InvMixColumns(state XOR round_key)) and return to SBOX.
REQ-021 MAIN with round = 0 SHALL load state = state XOR round_key, set ready, and go to IDLE.
REQ-022 Latency: ready SHALL rise on the edge 1 + Nr*(4/SBOX_WORDS + 1) edges after the edge that sampled next.
- SBOX_WORDS=1: 51 / 61 / 71 edges for AES-128 / AES-192 / AES-256.
- SBOX_WORDS=4: 21 / 25 / 29 edges.
REQ-023 round SHALL equal the round counter register; the S-box word counter SHALL wrap modulo 4/SBOX_WORDS.
REQ-024 new_block SHALL hold its value while in IDLE.
REQ-025 A back-to-back next, asserted in the cycle ready rises, SHALL start a new run immediately.

Reset
REQ-026 Reset SHALL take effect immediately on reset_n low, mid-run included, and set:
- state register to zero, so new_block = 0;
- round = 0, word counter = 0;
- ready = 1, keylen_err = 0;
- FSM to IDLE.
REQ-027 The first start after reset release SHALL behave identically to any other start.

Configuration
REQ-028 Macro AES_DEC_ABORT_EN, when defined, SHALL add input port abort (1 bit).
- abort=1 in INIT, SBOX or MAIN SHALL, on the next edge: go to IDLE, clear the state register to zero, set ready, and set round to 0.
- abort SHALL win over every other transition in that cycle.
- abort SHALL be ignored in IDLE.
REQ-029 Without AES_DEC_ABORT_EN, the abort port SHALL be absent and the behaviour SHALL be as in REQ-012 to REQ-025.

Verification
The bench supplies round_key from an expanded-key model indexed by round. Vectors use FIPS-197 key 000102...1f (truncated as needed).
REQ-030 AES-128: block 69c4e0d86a7b0430d8cdb78070b4c55a, SBOX_WORDS=1 -> new_block 00112233445566778899aabbccddeeff, with ready rising 51 edges after start.
REQ-031 AES-192: block dda97ca4864cdfe06eaf70a0ec0d7191, SBOX_WORDS=2 -> same plaintext, with ready rising 1+12*3 = 37 edges after start.
REQ-032 AES-256: block 8ea2b7ca516745bfeafc49904b496089, SBOX_WORDS=4 -> same plaintext in 29 edges; keylen toggled mid-run -> result unchanged.
REQ-033 keylen=11 with next=1 -> keylen_err high for exactly 1 cycle, ready stays 1, round stays unchanged.
REQ-034 reset_n low at edge 20 of an AES-128 run -> immediately new_block=0, ready=1, round=0; a following run returns the correct plaintext.
REQ-035 With AES_DEC_ABORT_EN, abort at edge 10 -> on the next edge ready=1 and new_block=0; next asserted together with abort is ignored.
